// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: readback monitor for a scanned 7-segment bus.
// Waits for each digit dwell to settle, decodes it, rebuilds the value.
module seg7_scan_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       an_n,
  input  logic [6:0]       seg_n,
  input  logic             clr_err,
  output logic [31:0]      digits,
  output logic [7:0]       digit_valid,
  output logic             cap_valid,
  output logic [2:0]       cap_idx,
  output logic [3:0]       cap_digit,
  output logic             bad_pattern,
  output logic             frame_done,
  output logic [ERR_W-1:0] err_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [14:0]   pins;
  logic [14:0]   smp;
  logic [CW-1:0] cnt;
  logic          armed;
  logic [7:0]    seen;
  logic [7:0]    seen_nxt;
  logic [7:0]    low;
  logic          active;
  logic [2:0]    idx;
  logic          legal;
  logic [3:0]    nib;
  logic          fire;

  assign pins = {an_n, seg_n};
  assign low = ~smp[14:7];
  assign active = (low != 8'd0) &&
                  ((low & (low - 8'd1)) == 8'd0);

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (low[i]) idx = 3'(i);
  end

  always_comb begin
    legal = 1'b1;
    nib = 4'h0;
    unique case (smp[6:0])
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default:    legal = 1'b0;
    endcase
  end

  // armed is the once-per-dwell latch; only a sample change re-arms it
  assign fire = armed && (cnt == CMAX) && active;
  assign seen_nxt = seen | (8'd1 << idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      smp   <= 15'h7FFF;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      smp <= pins;
      if (pins != smp) begin
        cnt   <= CW'(1);
        armed <= 1'b1;
      end else begin
        if (cnt != CMAX) cnt <= cnt + CW'(1);
        if (fire) armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= '0;
      digit_valid <= '0;
      cap_valid   <= 1'b0;
      cap_idx     <= '0;
      cap_digit   <= '0;
      bad_pattern <= 1'b0;
      frame_done  <= 1'b0;
      seen        <= '0;
    end else begin
      cap_valid   <= fire && legal;
      bad_pattern <= fire && !legal;
      frame_done  <= fire && (seen_nxt == 8'hFF);
      if (fire) begin
        cap_idx <= idx;
        seen    <= (seen_nxt == 8'hFF) ? 8'h00 : seen_nxt;
        if (legal) begin
          digits[4*idx +: 4] <= nib;
          digit_valid[idx]   <= 1'b1;
          cap_digit          <= nib;
        end else begin
          digit_valid[idx] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_err)
      err_count <= '0;
    else if (fire && !legal && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: vector table, directed corners and random scans
// checked against a sample-history reference model.
module tb_seg7_scan_capture;

  localparam int S = 4;
  localparam logic [14:0] IDLE = 15'h7FFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] an_n = 8'hFF;
  logic [6:0] seg_n = 7'h7F;
  logic       clr_err = 1'b0;
  logic [31:0] digits;
  logic [7:0] digit_valid;
  logic       cap_valid;
  logic [2:0] cap_idx;
  logic [3:0] cap_digit;
  logic       bad_pattern;
  logic       frame_done;
  logic [7:0] err_count;

  seg7_scan_capture #(.STABLE_CYCLES(S), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .an_n(an_n), .seg_n(seg_n),
    .clr_err(clr_err), .digits(digits),
    .digit_valid(digit_valid), .cap_valid(cap_valid),
    .cap_idx(cap_idx), .cap_digit(cap_digit),
    .bad_pattern(bad_pattern), .frame_done(frame_done),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [6:0] codes [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int n_chk = 0;
  int n_fail = 0;
  int ncap, nbad, nframe;

  logic [31:0] e_digits;
  logic [7:0]  e_valid, e_seen, e_err;
  logic        e_cap, e_bad, e_frame;
  logic [2:0]  e_idx;
  logic [3:0]  e_capd;
  logic [14:0] hist[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dec(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (codes[i] == s) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  // Capture at an edge iff the last S loaded samples are one value
  // that was not already loaded at the edge before them.
  task automatic model_edge(logic [7:0] a, logic [6:0] s, bit c, bit r);
    int n;
    bit f;
    logic [14:0] v;
    logic [7:0] lo, m;
    logic [4:0] d;
    int ix;
    if (r) begin
      e_digits = 0; e_valid = 0; e_seen = 0; e_err = 0;
      e_cap = 0; e_bad = 0; e_frame = 0; e_idx = 0; e_capd = 0;
      hist.delete();
      hist.push_back(IDLE);
      return;
    end
    e_cap = 0; e_bad = 0; e_frame = 0;
    n = hist.size();
    f = 0;
    v = '0;
    if (n >= S) begin
      v = hist[n-1];
      f = 1;
      for (int j = 1; j <= S; j++) if (hist[n-j] != v) f = 0;
      if (n > S && hist[n-S-1] == v) f = 0;
    end
    lo = ~v[14:7];
    if (f && $countones(lo) == 1) begin
      ix = 0;
      for (int i = 0; i < 8; i++) if (lo[i]) ix = i;
      d = dec(v[6:0]);
      e_idx = 3'(ix);
      if (d[4]) begin
        e_digits[4*ix +: 4] = d[3:0];
        e_valid[ix] = 1'b1;
        e_capd = d[3:0];
        e_cap = 1;
      end else begin
        e_valid[ix] = 1'b0;
        e_bad = 1;
      end
      m = e_seen | (8'd1 << ix);
      if (m == 8'hFF) begin e_frame = 1; e_seen = 0; end
      else e_seen = m;
    end
    if (c) e_err = 0;
    else if (e_bad && e_err != 8'hFF) e_err = e_err + 8'd1;
    hist.push_back({a, s});
    while (hist.size() > S + 1) void'(hist.pop_front());
  endtask

  task automatic step(logic [7:0] a, logic [6:0] s, bit c, bit r);
    @(negedge clk);
    an_n = a; seg_n = s; clr_err = c; rst = r;
    @(posedge clk);
    model_edge(a, s, c, r);
    #1;
    chk("m_digits", digits, e_digits);
    chk("m_valid", 32'(digit_valid), 32'(e_valid));
    chk("m_pulses", {cap_valid, bad_pattern, frame_done},
        {e_cap, e_bad, e_frame});
    chk("m_idx_dig", {cap_idx, cap_digit}, {e_idx, e_capd});
    chk("m_err", 32'(err_count), 32'(e_err));
    if (cap_valid) ncap++;
    if (bad_pattern) nbad++;
    if (frame_done) nframe++;
  endtask

  task automatic hold(logic [7:0] a, logic [6:0] s, int n, int clr_at = -1);
    for (int i = 0; i < n; i++) step(a, s, i == clr_at, 0);
  endtask

  typedef struct {
    logic [6:0] seg;
    logic [3:0] nib;
    bit         bad;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{7'b0000001, 4'h0, 0};
    tbl[1]  = '{7'b1001111, 4'h1, 0};
    tbl[2]  = '{7'b0010010, 4'h2, 0};
    tbl[3]  = '{7'b0000110, 4'h3, 0};
    tbl[4]  = '{7'b1001100, 4'h4, 0};
    tbl[5]  = '{7'b0100100, 4'h5, 0};
    tbl[6]  = '{7'b0100000, 4'h6, 0};
    tbl[7]  = '{7'b0001111, 4'h7, 0};
    tbl[8]  = '{7'b0000000, 4'h8, 0};
    tbl[9]  = '{7'b0000100, 4'h9, 0};
    tbl[10] = '{7'b0001000, 4'hA, 0};
    tbl[11] = '{7'b1100000, 4'hB, 0};
    tbl[12] = '{7'b0110001, 4'hC, 0};
    tbl[13] = '{7'b1000010, 4'hD, 0};
    tbl[14] = '{7'b0110000, 4'hE, 0};
    tbl[15] = '{7'b0111000, 4'hF, 0};
    tbl[16] = '{7'b1111111, 4'h0, 1};
    tbl[17] = '{7'b1111110, 4'h0, 1};
    tbl[18] = '{7'b0101010, 4'h0, 1};

    step(8'hFF, 7'h7F, 0, 1);
    step(8'hFF, 7'h7F, 0, 1);
    chk("reset_outs",
        {digit_valid, cap_valid, cap_idx, cap_digit,
         bad_pattern, frame_done, err_count}, 32'd0);
    chk("reset_digits", digits, 32'd0);

    // latency: stable from edge k, capture at edge k+4
    hold(8'hFE, 7'b0010010, 4);
    chk("t1_early", 32'(cap_valid), 32'd0);
    step(8'hFE, 7'b0010010, 0, 0);
    chk("t1_cap", {cap_valid, cap_idx, digits[3:0], digit_valid},
        {1'b1, 3'd0, 4'h2, 8'h01});

    step(8'hFF, 7'h7F, 0, 0);
    ncap = 0;
    hold(8'hFE, 7'b0010010, 20);
    chk("t2_once", ncap, 1);

    ncap = 0;
    hold(8'hFE, 7'b1001111, 3);
    hold(8'hFE, 7'b0111000, 4);
    chk("t3_glitch", ncap, 0);
    step(8'hFE, 7'b0111000, 0, 0);
    chk("t3_cap", {ncap[3:0], cap_valid, cap_digit}, {4'd1, 1'b1, 4'hF});

    for (int j = 0; j < 19; j++) begin
      hold(~(8'd1 << (j % 8)), tbl[j].seg, 5);
      chk("tbl_pulse", {cap_valid, bad_pattern}, {!tbl[j].bad, tbl[j].bad});
      chk("tbl_idx", 32'(cap_idx), j % 8);
      if (!tbl[j].bad) chk("tbl_nib", 32'(cap_digit), 32'(tbl[j].nib));
    end

    step(8'hFF, 7'h7F, 0, 1);
    nframe = 0;
    for (int d = 0; d < 8; d++) begin
      hold(~(8'd1 << d), codes[d+1], 6);
      chk("t4_frame", nframe, (d == 7) ? 1 : 0);
    end
    chk("t4_digits", digits, 32'h87654321);
    chk("t4_valid", 32'(digit_valid), 32'hFF);

    hold(8'hFB, 7'h7F, 5);
    chk("t5_bad", {bad_pattern, err_count, digit_valid[2], digits[11:8]},
        {1'b1, 8'd1, 1'b0, 4'h3});
    for (int i = 0; i < 300; i++)
      hold(8'hFB, (i % 2 == 0) ? 7'h7E : 7'h7F, 5);
    chk("t5_sat", 32'(err_count), 32'd255);
    hold(8'hFB, 7'h7E, 5, 4);
    chk("t5_clr", {bad_pattern, err_count}, {1'b1, 8'd0});

    ncap = 0; nbad = 0; nframe = 0;
    hold(8'hF0, 7'b0000001, 10);
    hold(8'hFF, 7'b0000001, 10);
    chk("t6_inactive", ncap + nbad + nframe, 0);
    hold(8'hFD, 7'b0000110, 3);
    step(8'hFD, 7'b0000110, 0, 1);
    chk("t6_rst", {digit_valid, cap_valid, cap_idx, cap_digit,
                   bad_pattern, frame_done, err_count}, 32'd0);
    chk("t6_rst_dig", digits, 32'd0);
    chk("t6_nocap", ncap, 0);

    for (int k = 0; k < 400; k++) begin
      int r;
      logic [7:0] a;
      logic [6:0] s;
      r = $urandom_range(0, 9);
      if (r < 7) a = ~(8'd1 << $urandom_range(0, 7));
      else if (r == 7) a = 8'hFF;
      else a = 8'($urandom);
      if ($urandom_range(0, 9) < 7) s = codes[$urandom_range(0, 15)];
      else s = 7'($urandom);
      if ($urandom_range(0, 199) == 0) step(a, s, 0, 1);
      for (int i = $urandom_range(1, 7); i > 0; i--)
        step(a, s, $urandom_range(0, 19) == 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
